// File: rtl/rggen_rtl_pkg.sv
// Shared rggen definitions: access codes, AXI/rggen status codes, bridge state encoding
// and small decode helpers used by the AXI4-Lite bridge.
package rggen_rtl_pkg;

    localparam logic [1:0] RGGEN_WRITE = 2'b11;
    localparam logic [1:0] RGGEN_READ  = 2'b10;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } rggen_status_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ADDRESS  = 2'b01,
        ST_RESPONSE = 2'b10,
        ST_DONE     = 2'b11
    } bridge_state_e;

    // Bit 0 of the access code distinguishes write from read.
    function automatic logic is_write_access(input logic [1:0] access);
        return access[0];
    endfunction

    // SLVERR and DECERR both carry resp[1] = 1.
    function automatic logic is_error_resp(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite initiator turning one rggen bus request into one AXI4-Lite read or write.
// Optional error-response counter enabled by defining RGGEN_AXI4LITE_BRIDGE_ERR_COUNT_EN.
module rggen_axi4lite_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int         ADDRESS_WIDTH = 16,
    parameter int         BUS_WIDTH     = 32,
    parameter logic [2:0] AXPROT        = 3'b000
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_bus_valid,
    input  logic [1:0]                 i_bus_access,
    input  logic [ADDRESS_WIDTH-1:0]   i_bus_address,
    input  logic [BUS_WIDTH-1:0]       i_bus_write_data,
    input  logic [BUS_WIDTH/8-1:0]     i_bus_strobe,
    output logic                       o_bus_ready,
    output logic [1:0]                 o_bus_status,
    output logic [BUS_WIDTH-1:0]       o_bus_read_data,
    output logic                       o_awvalid,
    input  logic                       i_awready,
    output logic [ADDRESS_WIDTH-1:0]   o_awaddr,
    output logic [2:0]                 o_awprot,
    output logic                       o_wvalid,
    input  logic                       i_wready,
    output logic [BUS_WIDTH-1:0]       o_wdata,
    output logic [BUS_WIDTH/8-1:0]     o_wstrb,
    input  logic                       i_bvalid,
    output logic                       o_bready,
    input  logic [1:0]                 i_bresp,
    output logic                       o_arvalid,
    input  logic                       i_arready,
    output logic [ADDRESS_WIDTH-1:0]   o_araddr,
    output logic [2:0]                 o_arprot,
    input  logic                       i_rvalid,
    output logic                       o_rready,
    input  logic [BUS_WIDTH-1:0]       i_rdata,
    input  logic [1:0]                 i_rresp,
    input  logic                       i_error_count_clear,
    output logic [15:0]                o_error_count
);

    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    bridge_state_e              state_q,       state_d;
    logic                       write_q,       write_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q,        addr_d;
    logic [BUS_WIDTH-1:0]       wdata_q,       wdata_d;
    logic [STRB_WIDTH-1:0]      strb_q,        strb_d;
    logic                       awvalid_q,     awvalid_d;
    logic                       wvalid_q,      wvalid_d;
    logic                       arvalid_q,     arvalid_d;
    logic                       bready_q,      bready_d;
    logic                       rready_q,      rready_d;
    logic                       bus_ready_q,   bus_ready_d;
    logic [1:0]                 status_q,      status_d;
    logic [BUS_WIDTH-1:0]       rdata_q,       rdata_d;
    logic [15:0]                error_count_q, error_count_d;
    logic                       resp_accept_s;
    logic [1:0]                 resp_s;
    logic                       unused_s;

    // Next-state and output-flop logic of the transaction FSM.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        strb_d        = strb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        bus_ready_d   = 1'b0;
        status_d      = status_q;
        rdata_d       = rdata_q;
        resp_accept_s = (bready_q && i_bvalid) || (rready_q && i_rvalid);
        resp_s        = bready_q ? i_bresp : i_rresp;
        case (state_q)
            ST_IDLE: begin
                if (i_bus_valid) begin
                    write_d   = is_write_access(i_bus_access);
                    addr_d    = i_bus_address;
                    wdata_d   = i_bus_write_data;
                    strb_d    = i_bus_strobe;
                    awvalid_d = is_write_access(i_bus_access);
                    wvalid_d  = is_write_access(i_bus_access);
                    arvalid_d = !is_write_access(i_bus_access);
                    state_d   = ST_ADDRESS;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ADDRESS: begin
                // Each channel retires on its own handshake; the phase ends when all have.
                awvalid_d = awvalid_q && !i_awready;
                wvalid_d  = wvalid_q  && !i_wready;
                arvalid_d = arvalid_q && !i_arready;
                if (!awvalid_d && !wvalid_d && !arvalid_d) begin
                    bready_d = write_q;
                    rready_d = !write_q;
                    state_d  = ST_RESPONSE;
                end else begin
                    state_d  = ST_ADDRESS;
                end
            end
            ST_RESPONSE: begin
                if (resp_accept_s) begin
                    bready_d    = 1'b0;
                    rready_d    = 1'b0;
                    status_d    = resp_s;
                    bus_ready_d = 1'b1;
                    state_d     = ST_DONE;
                    if (!write_q) begin
                        rdata_d = i_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = ST_RESPONSE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
                bready_d  = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

`ifdef RGGEN_AXI4LITE_BRIDGE_ERR_COUNT_EN
    // Saturating error-response counter; clear takes priority over increment.
    always_comb begin
        unused_s = i_bus_access[1];
        if (i_error_count_clear) begin
            error_count_d = 16'h0000;
        end else if (resp_accept_s && is_error_resp(resp_s) && (error_count_q != 16'hFFFF)) begin
            error_count_d = error_count_q + 16'h0001;
        end else begin
            error_count_d = error_count_q;
        end
    end
`else
    // Counter disabled: held at zero and the clear input has no effect.
    always_comb begin
        unused_s      = ^{i_bus_access[1], i_error_count_clear};
        error_count_d = 16'h0000;
    end
`endif

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            addr_q        <= {ADDRESS_WIDTH{1'b0}};
            wdata_q       <= {BUS_WIDTH{1'b0}};
            strb_q        <= {STRB_WIDTH{1'b0}};
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            bus_ready_q   <= 1'b0;
            status_q      <= 2'b00;
            rdata_q       <= {BUS_WIDTH{1'b0}};
            error_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            strb_q        <= strb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            bus_ready_q   <= bus_ready_d;
            status_q      <= status_d;
            rdata_q       <= rdata_d;
            error_count_q <= error_count_d;
        end
    end

    assign o_bus_ready     = bus_ready_q;
    assign o_bus_status    = status_q;
    assign o_bus_read_data = rdata_q;
    assign o_awvalid       = awvalid_q;
    assign o_awaddr        = addr_q;
    assign o_awprot        = AXPROT;
    assign o_wvalid        = wvalid_q;
    assign o_wdata         = wdata_q;
    assign o_wstrb         = strb_q;
    assign o_bready        = bready_q;
    assign o_arvalid       = arvalid_q;
    assign o_araddr        = addr_q;
    assign o_arprot        = AXPROT;
    assign o_rready        = rready_q;
    assign o_error_count   = error_count_q;

endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Directed, table-driven bench for rggen_axi4lite_bridge with a cycle-level AXI4-Lite slave model.
// Error-counter checks follow RGGEN_AXI4LITE_BRIDGE_ERR_COUNT_EN in the same way as the design.
module tb_rggen_axi4lite_bridge;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_bus_valid;
    logic [1:0]  i_bus_access;
    logic [15:0] i_bus_address;
    logic [31:0] i_bus_write_data;
    logic [3:0]  i_bus_strobe;
    logic        o_bus_ready;
    logic [1:0]  o_bus_status;
    logic [31:0] o_bus_read_data;
    logic        o_awvalid, i_awready;
    logic [15:0] o_awaddr;
    logic [2:0]  o_awprot;
    logic        o_wvalid, i_wready;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        i_bvalid, o_bready;
    logic [1:0]  i_bresp;
    logic        o_arvalid, i_arready;
    logic [15:0] o_araddr;
    logic [2:0]  o_arprot;
    logic        i_rvalid, o_rready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_error_count_clear;
    logic [15:0] o_error_count;

    int n_cmp = 0;
    int n_bad = 0;

    rggen_axi4lite_bridge dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_bus_valid(i_bus_valid), .i_bus_access(i_bus_access), .i_bus_address(i_bus_address),
        .i_bus_write_data(i_bus_write_data), .i_bus_strobe(i_bus_strobe),
        .o_bus_ready(o_bus_ready), .o_bus_status(o_bus_status), .o_bus_read_data(o_bus_read_data),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awprot(o_awprot),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arprot(o_arprot),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp),
        .i_error_count_clear(i_error_count_clear), .o_error_count(o_error_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          a_d;        // address-channel ready delay (AW or AR)
        int          w_d;        // W ready delay
        int          r_d;        // extra cycles before B/R valid
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          exp_ready;  // cycle of o_bus_ready, request presented in cycle 0
        logic [1:0]  exp_status;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_slave();
        i_awready = 1'b0; i_wready = 1'b0; i_arready = 1'b0;
        i_bvalid  = 1'b0; i_rvalid = 1'b0;
        i_bresp   = 2'b11; i_rresp = 2'b11; i_rdata = 32'hDEAD_DEAD;
    endtask

    // One request against the slave model; all events are counted and checked afterwards.
    task automatic run_vec(input vec_t v, input string tag);
        int  aw_n = 0, w_n = 0, ar_n = 0, aw_hs = 0, w_hs = 0, ar_hs = 0;
        int  rsp_hs = 0, rdy_n = 0, rdy_cyc = -1, done_cyc = -1, bad_rdy = 0;
        bit  rsp_taken = 1'b0;
        @(negedge i_clk);
        i_bus_valid      = 1'b1;
        i_bus_access     = v.wr ? 2'b11 : 2'b10;
        i_bus_address    = v.addr;
        i_bus_write_data = v.wdata;
        i_bus_strobe     = v.strb;
        for (int k = 1; k <= 40; k++) begin
            @(negedge i_clk);
            if (done_cyc >= 0 && !rsp_taken && k >= done_cyc + 1 + v.r_d) begin
                i_bvalid = v.wr; i_rvalid = !v.wr;
                i_bresp  = v.resp; i_rresp = v.resp; i_rdata = v.rdata;
            end else begin
                i_bvalid = 1'b0; i_rvalid = 1'b0;
                i_bresp  = 2'b11; i_rresp = 2'b11; i_rdata = 32'hDEAD_DEAD;
            end
            if ((o_bready && (!v.wr || done_cyc < 0 || rsp_taken)) ||
                (o_rready && (v.wr || done_cyc < 0 || rsp_taken)))
                bad_rdy++;
            if ((i_bvalid && o_bready) || (i_rvalid && o_rready)) begin
                rsp_hs++;
                rsp_taken = 1'b1;
            end
            i_awready = o_awvalid && (aw_n >= v.a_d);
            i_wready  = o_wvalid  && (w_n  >= v.w_d);
            i_arready = o_arvalid && (ar_n >= v.a_d);
            if (o_awvalid) begin
                aw_n++;
                if (i_awready) begin
                    aw_hs++;
                    chk({tag, "_awaddr"}, o_awaddr, v.addr);
                    chk({tag, "_awprot"}, o_awprot, 3'b000);
                end
            end
            if (o_wvalid) begin
                w_n++;
                if (i_wready) begin
                    w_hs++;
                    chk({tag, "_wdata"}, o_wdata, v.wdata);
                    chk({tag, "_wstrb"}, o_wstrb, v.strb);
                end
            end
            if (o_arvalid) begin
                ar_n++;
                if (i_arready) begin
                    ar_hs++;
                    chk({tag, "_araddr"}, o_araddr, v.addr);
                    chk({tag, "_arprot"}, o_arprot, 3'b000);
                end
            end
            if (done_cyc < 0 && (v.wr ? (aw_hs > 0 && w_hs > 0) : (ar_hs > 0)))
                done_cyc = k;
            if (o_bus_ready) begin
                rdy_n++;
                i_bus_valid = 1'b0;
                if (rdy_cyc < 0) begin
                    rdy_cyc = k;
                    chk({tag, "_status"}, o_bus_status, v.exp_status);
                    chk({tag, "_rdata"}, o_bus_read_data, v.exp_rdata);
                end
            end
            if (rdy_cyc >= 0 && k >= rdy_cyc + 2) break;
        end
        idle_slave();
        i_bus_valid = 1'b0;
        chk({tag, "_ready_cycle"}, rdy_cyc, v.exp_ready);
        chk({tag, "_ready_pulses"}, rdy_n, 1);
        chk({tag, "_resp_handshakes"}, rsp_hs, 1);
        chk({tag, "_readies_outside_resp"}, bad_rdy, 0);
        chk({tag, "_awvalid_cycles"}, aw_n, v.wr ? v.a_d + 1 : 0);
        chk({tag, "_wvalid_cycles"}, w_n, v.wr ? v.w_d + 1 : 0);
        chk({tag, "_arvalid_cycles"}, ar_n, v.wr ? 0 : v.a_d + 1);
    endtask

    initial begin
        int spur;
        vec_t r;
        vecs[0] = '{1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0000_0000, 3, 2'b00, 32'h0000_0000};
        vecs[1] = '{1'b1, 16'h0014, 32'hCAFE_F00D, 4'h3, 3, 0, 0, 2'b00, 32'h0000_0000, 6, 2'b00, 32'h0000_0000};
        vecs[2] = '{1'b0, 16'h0024, 32'h0000_0000, 4'h0, 0, 0, 4, 2'b10, 32'h1234_5678, 7, 2'b10, 32'h1234_5678};
        vecs[3] = '{1'b1, 16'h0030, 32'hA5A5_A5A5, 4'h5, 0, 2, 1, 2'b01, 32'h0000_0000, 6, 2'b01, 32'h1234_5678};
        vecs[4] = '{1'b0, 16'h0040, 32'h0000_0000, 4'h0, 2, 0, 0, 2'b00, 32'h0BAD_F00D, 5, 2'b00, 32'h0BAD_F00D};
        vecs[5] = '{1'b1, 16'h0050, 32'h1122_3344, 4'h8, 1, 1, 0, 2'b11, 32'h0000_0000, 4, 2'b11, 32'h0BAD_F00D};
        vecs[6] = '{1'b0, 16'hFFFC, 32'h0000_0000, 4'h0, 0, 0, 0, 2'b11, 32'hFFFF_FFFF, 3, 2'b11, 32'hFFFF_FFFF};

        i_rst_n = 1'b0;
        i_bus_valid = 1'b0; i_bus_access = 2'b00; i_bus_address = 16'h0000;
        i_bus_write_data = 32'h0000_0000; i_bus_strobe = 4'h0; i_error_count_clear = 1'b0;
        idle_slave();
        repeat (3) @(negedge i_clk);
        chk("reset_outputs", {o_bus_ready, o_bus_status, o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready},
            7'b0);
        chk("reset_read_data", o_bus_read_data, 32'h0000_0000);
        chk("reset_error_count", o_error_count, 16'h0000);
        i_rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Responses offered while idle must be ignored.
        spur = 0;
        @(negedge i_clk);
        i_bvalid = 1'b1; i_rvalid = 1'b1; i_bresp = 2'b10; i_rresp = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            if (o_bready || o_rready || o_bus_ready) spur++;
        end
        idle_slave();
        chk("spurious_resp_ignored", spur, 0);

`ifdef RGGEN_AXI4LITE_BRIDGE_ERR_COUNT_EN
        chk("err_count_after_table", o_error_count, 16'd3);
`else
        chk("err_count_disabled", o_error_count, 16'd0);
`endif

        // Asynchronous reset while the write address phase is stalled.
        @(negedge i_clk);
        i_bus_valid = 1'b1; i_bus_access = 2'b11; i_bus_address = 16'h0070;
        i_bus_write_data = 32'h7777_7777; i_bus_strobe = 4'hF;
        @(negedge i_clk);
        chk("pre_reset_awvalid", o_awvalid, 1'b1);
        #2 i_rst_n = 1'b0;
        #1 chk("async_reset_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_bus_ready}, 6'b0);
        i_bus_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        r = '{1'b0, 16'h0060, 32'h0000_0000, 4'h0, 0, 0, 0, 2'b00, 32'h600D_CAFE, 3, 2'b00, 32'h600D_CAFE};
        run_vec(r, "post_reset");

`ifdef RGGEN_AXI4LITE_BRIDGE_ERR_COUNT_EN
        r = '{1'b0, 16'h0100, 32'h0000_0000, 4'h0, 0, 0, 0, 2'b11, 32'h0000_0100, 3, 2'b11, 32'h0000_0100};
        for (int i = 0; i < 3; i++) run_vec(r, "decerr");
        chk("err_count_three", o_error_count, 16'd3);
        i_error_count_clear = 1'b1;
        run_vec(r, "decerr_clear");
        i_error_count_clear = 1'b0;
        @(negedge i_clk);
        chk("err_count_clear_wins", o_error_count, 16'd0);
        force dut.error_count_q = 16'hFFFF;
        @(negedge i_clk);
        release dut.error_count_q;
        run_vec(r, "decerr_sat");
        chk("err_count_saturated", o_error_count, 16'hFFFF);
`else
        i_error_count_clear = 1'b1;
        run_vec(vecs[6], "clear_ignored");
        i_error_count_clear = 1'b0;
        chk("err_count_still_zero", o_error_count, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
